// File: rtl/fpnew_pkg.sv
// Shared FPU request types: operation/format enums and the width-independent request fields.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  // Operands and tag are sized per instance, so they live beside this struct in each entry.
  typedef struct packed {
    roundmode_e  rnd_mode;
    operation_e  op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    logic        vectorial_op;
  } fpu_req_t;

endpackage

// File: rtl/fpnew_issue_queue.sv
// In-order request queue between the issue stage and the FPU top: registered head,
// no fall-through, flushable, occupancy reported on usage_o.
module fpnew_issue_queue
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 5,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [2:0][WIDTH-1:0]             operands_i,
  input  roundmode_e                        rnd_mode_i,
  input  operation_e                        op_i,
  input  logic                              op_mod_i,
  input  fp_format_e                        src_fmt_i,
  input  fp_format_e                        dst_fmt_i,
  input  int_format_e                       int_fmt_i,
  input  logic                              vectorial_op_i,
  input  logic [TAG_WIDTH-1:0]              tag_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              flush_i,
  output logic [2:0][WIDTH-1:0]             operands_o,
  output roundmode_e                        rnd_mode_o,
  output operation_e                        op_o,
  output logic                              op_mod_o,
  output fp_format_e                        src_fmt_o,
  output fp_format_e                        dst_fmt_o,
  output int_format_e                       int_fmt_o,
  output logic                              vectorial_op_o,
  output logic [TAG_WIDTH-1:0]              tag_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]        usage_o,
  output logic                              busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_depth_check
    $error("fpnew_issue_queue: DEPTH must be at least 2");
  end

  typedef struct packed {
    logic [2:0][WIDTH-1:0] operands;
    fpu_req_t              req;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   usage_q, usage_d;
  logic               push, pop;

  // Handshake flags depend only on stored occupancy, never on the incoming valid/ready.
  assign in_ready_o  = (usage_q != CNT_W'(DEPTH));
  assign out_valid_o = (usage_q != '0);
  assign usage_o     = usage_q;
  assign busy_o      = (usage_q != '0);

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_entry.operands         = operands_i;
    wr_entry.req.rnd_mode     = rnd_mode_i;
    wr_entry.req.op           = op_i;
    wr_entry.req.op_mod       = op_mod_i;
    wr_entry.req.src_fmt      = src_fmt_i;
    wr_entry.req.dst_fmt      = dst_fmt_i;
    wr_entry.req.int_fmt      = int_fmt_i;
    wr_entry.req.vectorial_op = vectorial_op_i;
    wr_entry.tag              = tag_i;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      usage_d = usage_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head           = mem_q[rd_ptr_q];
  assign operands_o     = head.operands;
  assign rnd_mode_o     = head.req.rnd_mode;
  assign op_o           = head.req.op;
  assign op_mod_o       = head.req.op_mod;
  assign src_fmt_o      = head.req.src_fmt;
  assign dst_fmt_o      = head.req.dst_fmt;
  assign int_fmt_o      = head.req.int_fmt;
  assign vectorial_op_o = head.req.vectorial_op;
  assign tag_o          = head.tag;

endmodule

// File: tb/tb_fpnew_issue_queue.sv
// Self-checking bench for fpnew_issue_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fpnew_issue_queue;
  import fpnew_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned TW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned UW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0][W-1:0] ops;
    roundmode_e        rnd;
    operation_e        op;
    logic              mod;
    fp_format_e        src;
    fp_format_e        dst;
    int_format_e       ifmt;
    logic              vec;
    logic [TW-1:0]     tag;
  } pl_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [2:0][W-1:0] operands_i, operands_o;
  roundmode_e        rnd_mode_i, rnd_mode_o;
  operation_e        op_i, op_o;
  logic              op_mod_i, op_mod_o;
  fp_format_e        src_fmt_i, src_fmt_o, dst_fmt_i, dst_fmt_o;
  int_format_e       int_fmt_i, int_fmt_o;
  logic              vectorial_op_i, vectorial_op_o;
  logic [TW-1:0]     tag_i, tag_o;
  logic              in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i, busy_o;
  logic [UW-1:0]     usage_o;

  fpnew_issue_queue #(.WIDTH(W), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .operands_i(operands_i), .rnd_mode_i(rnd_mode_i), .op_i(op_i), .op_mod_i(op_mod_i),
    .src_fmt_i(src_fmt_i), .dst_fmt_i(dst_fmt_i), .int_fmt_i(int_fmt_i),
    .vectorial_op_i(vectorial_op_i), .tag_i(tag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
    .operands_o(operands_o), .rnd_mode_o(rnd_mode_o), .op_o(op_o), .op_mod_o(op_mod_o),
    .src_fmt_o(src_fmt_o), .dst_fmt_o(dst_fmt_o), .int_fmt_o(int_fmt_o),
    .vectorial_op_o(vectorial_op_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .usage_o(usage_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks   = 0;
  int   failures = 0;
  pl_t  model_q[$];
  int   popped[$];
  logic last_acc;
  int   max_usage;
  logic hold_on;
  pl_t  hold_exp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t rand_pl();
    logic [127:0] r;
    pl_t p;
    r = {$urandom, $urandom, $urandom, $urandom};
    p = r[$bits(pl_t)-1:0];
    return p;
  endfunction

  function automatic pl_t observed_pl();
    pl_t p;
    p.ops = operands_o; p.rnd = rnd_mode_o; p.op = op_o; p.mod = op_mod_o;
    p.src = src_fmt_o; p.dst = dst_fmt_o; p.ifmt = int_fmt_o; p.vec = vectorial_op_o;
    p.tag = tag_o;
    return p;
  endfunction

  // Compare every visible output against the model's current contents.
  task automatic check_outputs();
    int n;
    n = model_q.size();
    if (int'(usage_o) > max_usage) max_usage = int'(usage_o);
    chk("usage", 128'(usage_o), 128'(n));
    chk("in_ready", 128'(in_ready_o), 128'(n != DEPTH));
    chk("out_valid", 128'(out_valid_o), 128'(n != 0));
    chk("busy", 128'(busy_o), 128'(n != 0));
    if (n != 0) chk("head_payload", 128'(observed_pl()), 128'(model_q[0]));
    if (hold_on) chk("hold_stable", 128'(observed_pl()), 128'(hold_exp));
  endtask

  // One clock: check at the falling edge, drive the new inputs, then advance the model.
  task automatic cycle(input logic v, input pl_t p, input logic rdy, input logic fl);
    logic acc, pop;
    @(negedge clk_i);
    check_outputs();
    in_valid_i = v; out_ready_i = rdy; flush_i = fl;
    operands_i = p.ops; rnd_mode_i = p.rnd; op_i = p.op; op_mod_i = p.mod;
    src_fmt_i = p.src; dst_fmt_i = p.dst; int_fmt_i = p.ifmt; vectorial_op_i = p.vec;
    tag_i = p.tag;
    acc = v && (model_q.size() != DEPTH);
    pop = rdy && (model_q.size() != 0);
    last_acc = acc && !fl;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) begin
        popped.push_back(int'(model_q[0].tag));
        void'(model_q.pop_front());
      end
      if (acc) model_q.push_back(p);
    end
  endtask

  initial begin
    pl_t p;
    int  next_tag, n;
    hold_on = 1'b0; max_usage = 0; last_acc = 1'b0;
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    p = rand_pl();
    operands_i = p.ops; rnd_mode_i = p.rnd; op_i = p.op; op_mod_i = p.mod;
    src_fmt_i = p.src; dst_fmt_i = p.dst; int_fmt_i = p.ifmt; vectorial_op_i = p.vec;
    tag_i = p.tag;
    #12;
    check_outputs();
    #5 rst_ni = 1'b1;

    // Single push of tag 3, then pop it.
    p = rand_pl(); p.tag = TW'(3);
    cycle(1'b1, p, 1'b1, 1'b0);
    cycle(1'b0, rand_pl(), 1'b1, 1'b0);
    cycle(1'b0, rand_pl(), 1'b1, 1'b0);

    // Fill to DEPTH with backpressure; a fifth offer must be refused.
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_pl(), 1'b0, 1'b0);
    // Full with simultaneous offer and pop: pop only.
    cycle(1'b1, rand_pl(), 1'b1, 1'b0);
    cycle(1'b0, rand_pl(), 1'b0, 1'b0);

    // Flush at usage 3 with a push in the same cycle.
    cycle(1'b1, rand_pl(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_pl(), 1'b1, 1'b0);

    // Backpressure stability on a single held head.
    hold_exp = rand_pl();
    cycle(1'b1, hold_exp, 1'b0, 1'b0);
    hold_on = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_pl(), 1'b0, 1'b0);
    cycle(1'b0, rand_pl(), 1'b1, 1'b0);
    hold_on = 1'b0;
    cycle(1'b0, rand_pl(), 1'b0, 1'b1);

    // Wrap-around: tags 0..9 through the queue with random readiness.
    popped.delete(); next_tag = 0; n = 0; max_usage = 0;
    while (popped.size() < 10 && n < 300) begin
      p = rand_pl(); p.tag = TW'(next_tag);
      cycle((next_tag < 10) && ($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 1)), 1'b0);
      if (last_acc) next_tag++;
      n++;
    end
    chk("wrap_count", 128'(popped.size()), 128'(10));
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("wrap_order", 128'(popped[i]), 128'(i));
    chk("wrap_max_usage", 128'(max_usage <= int'(DEPTH)), 128'(1));

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), rand_pl(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));

    // Asynchronous reset mid-operation drops everything immediately.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_pl(), 1'b0, 1'b0);
    @(negedge clk_i);
    check_outputs();
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    model_q.delete();
    check_outputs();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    p = rand_pl();
    cycle(1'b1, p, 1'b0, 1'b0);
    cycle(1'b0, rand_pl(), 1'b1, 1'b0);
    cycle(1'b0, rand_pl(), 1'b0, 1'b0);
    @(negedge clk_i);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
